// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared state encoding, default timing constants and request error causes
package ro_meas_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, GATE, DRAIN, DONE} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PRESCALE_BITS = 3;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SEL = 2'd1;
  localparam logic [1:0] ERR_GATE = 2'd2;
  function automatic logic [1:0] req_cause(input int sel, input int num_ro, input logic gate_zero);
    return sel >= num_ro ? ERR_SEL : gate_zero ? ERR_GATE : ERR_NONE;
  endfunction
endpackage

// File: rtl/ro_prescaler.sv
// ro_prescaler: RO-domain divider, held cleared while its oscillator is disabled
module ro_prescaler
  import ro_meas_pkg::*;
#(
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
  input  logic ro,
  input  logic en,
  output logic msb
);
  logic [PRESCALE_BITS-1:0] cnt;
  // free-running divider on the raw oscillator, async clear keeps it idle when disabled
  always_ff @(posedge ro or negedge en)
    if (!en) cnt <= '0;
    else cnt <= cnt + 1'b1;
  assign msb = cnt[PRESCALE_BITS-1];
endmodule

// File: rtl/ro_meas_ctrl.sv
// ro_meas_ctrl: runs one ring oscillator at a time and counts its prescaled edges over a clk window
module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter int NUM_RO = 4,
  parameter int SEL_W = 2,
  parameter int GATE_W = 16,
  parameter int CNT_W = 24,
  parameter int SETTLE_CYCLES = 16,
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  ro_sel,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [NUM_RO-1:0] ro_enable,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              err
);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W = GATE_W > SET_W ? GATE_W : SET_W;
  state_t state, state_nxt;
  logic [SEL_W-1:0] sel_q;
  logic [GATE_W-1:0] gate_q;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [NUM_RO-1:0] en_nxt, ro_msb;
  logic [2**SEL_W-1:0] msb_pad;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
  logic sync_d, rise, accept;
  logic [1:0] cause;
  for (genvar k = 0; k < NUM_RO; k++) begin : g_pre
    ro_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_pre (
      .ro (ro_in[k]),
      .en (ro_enable[k]),
      .msb(ro_msb[k])
    );
  end
  assign cause = req_cause(int'(ro_sel), NUM_RO, gate_cycles == '0);
  assign accept = state == IDLE && start;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign msb_pad = (2**SEL_W)'(ro_msb);
  assign rise = sync[SYNC_STAGES-1] & ~sync_d;
  // sequencing: timer reloads on every phase change, ro_enable only moves with the state
  always_comb begin
    state_nxt = state;
    tmr_nxt = tmr;
    en_nxt = ro_enable;
    case (state)
      IDLE: if (start) begin
        state_nxt = cause == ERR_NONE ? SETTLE : DONE;
        tmr_nxt = TMR_W'(SETTLE_CYCLES - 1);
        en_nxt = cause == ERR_NONE ? NUM_RO'(1) << ro_sel : '0;
      end
      SETTLE: if (tmr == '0) begin
        state_nxt = GATE;
        tmr_nxt = TMR_W'(gate_q - 1'b1);
      end else tmr_nxt = tmr - 1'b1;
      GATE: if (tmr == '0) begin
        state_nxt = DRAIN;
        tmr_nxt = TMR_W'(SYNC_STAGES);
        en_nxt = '0;
      end else tmr_nxt = tmr - 1'b1;
      DRAIN: if (tmr == '0) state_nxt = DONE;
        else tmr_nxt = tmr - 1'b1;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // state, timer, enables and the request captured at accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tmr <= '0;
      ro_enable <= '0;
      sel_q <= '0;
      gate_q <= '0;
    end else begin
      state <= state_nxt;
      tmr <= tmr_nxt;
      ro_enable <= en_nxt;
      if (accept) begin
        sel_q <= ro_sel;
        gate_q <= gate_cycles;
      end
    end
  // only the selected prescaler MSB crosses into clk, plus one extra flop for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      sync_d <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], msb_pad[sel_q]};
      sync_d <= sync[SYNC_STAGES-1];
    end
  // result registers: cleared on accept, saturating count during the gate window only
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      overflow <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      count <= '0;
      overflow <= 1'b0;
      err <= cause != ERR_NONE;
    end else if (state == GATE && rise) begin
      if (&count) overflow <= 1'b1;
      else count <= count + 1'b1;
    end
endmodule

// File: tb/tb_ro_meas_ctrl.sv
// tb_ro_meas_ctrl: randomized oscillator frequencies checked against an ideal frequency-ratio model
`timescale 1ns/1ps
module tb_ro_meas_ctrl;
  localparam int NUM_RO = 4;
  localparam int SEL_W = 3;
  localparam int GATE_W = 16;
  localparam int CNT_W = 8;
  localparam int SETTLE = 16;
  localparam int PB = 3;
  localparam int SS = 2;
  localparam real TCLK = 10.0;
  localparam int CMAX = 2**CNT_W - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [SEL_W-1:0] ro_sel = '0;
  logic [GATE_W-1:0] gate_cycles = '0;
  wire [NUM_RO-1:0] ro_in;
  logic [NUM_RO-1:0] ro_enable;
  logic busy, done, overflow, err;
  logic [CNT_W-1:0] count;
  real ro_half[NUM_RO] = '{10.0, 10.0, 10.0, 10.0};
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  ro_meas_ctrl #(
    .NUM_RO(NUM_RO), .SEL_W(SEL_W), .GATE_W(GATE_W), .CNT_W(CNT_W),
    .SETTLE_CYCLES(SETTLE), .PRESCALE_BITS(PB), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_sel(ro_sel), .gate_cycles(gate_cycles),
    .ro_in(ro_in), .ro_enable(ro_enable), .busy(busy), .done(done), .count(count),
    .overflow(overflow), .err(err)
  );
  // each oscillator toggles only while enabled and rests low otherwise
  for (genvar g = 0; g < NUM_RO; g++) begin : g_ro
    logic r = 1'b0;
    assign ro_in[g] = r;
    initial forever begin
      #(ro_half[g]);
      r = ro_enable[g] ? ~r : 1'b0;
    end
  end
  // expected edges in the window: window time divided by the prescaled period
  function automatic real ideal(input real half, input int g);
    return g * TCLK / (2.0 * half * (2**PB));
  endfunction
  function automatic int exp_lat(input int g);
    return 1 + SETTLE + g + SS + 1;
  endfunction
  task automatic run_meas(input int sel, input int g, input bit hold, output int lat,
                          output logic [CNT_W-1:0] c, output logic ov, output logic er,
                          output bit en_bad, output bit busy_bad);
    logic [NUM_RO-1:0] ok_en;
    ok_en = NUM_RO'(1) << sel;
    @(posedge clk); #1;
    start = 1'b1;
    ro_sel = SEL_W'(sel);
    gate_cycles = GATE_W'(g);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = -1;
    en_bad = 1'b0;
    busy_bad = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      if (ro_enable !== '0 && ro_enable !== ok_en) en_bad = 1'b1;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    c = count;
    ov = overflow;
    er = err;
    if (hold) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask
  task automatic check_valid(input string name, input int sel, input int g, input int lat,
                             input logic [CNT_W-1:0] c, input logic ov, input logic er,
                             input bit en_bad, input bit busy_bad);
    real e, d;
    e = ideal(ro_half[sel], g);
    d = real'(c) - e;
    vecs++;
    if (lat !== exp_lat(g)) begin
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat(g));
      errs++;
    end
    vecs++;
    if (d > 1.0 || d < -1.0) begin
      $display("FAIL %s count: got %0d expected %0.2f +/-1", name, c, e);
      errs++;
    end
    vecs++;
    if ({ov, er} !== 2'b00) begin
      $display("FAIL %s flags: got overflow=%b err=%b expected 0 0", name, ov, er);
      errs++;
    end
    vecs++;
    if ({en_bad, busy_bad} !== 2'b00) begin
      $display("FAIL %s enable/busy: got en_bad=%b busy_bad=%b expected 0 0", name, en_bad, busy_bad);
      errs++;
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({ro_enable, busy, done, count, overflow, err} !== '0) begin
      $display("FAIL reset_hold: got en=%b busy=%b done=%b count=%0d ov=%b err=%b expected all 0",
               ro_enable, busy, done, count, overflow, err);
      errs++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({ro_enable, busy, done, count, overflow, err} !== '0) begin
      $display("FAIL reset_idle: got en=%b busy=%b done=%b count=%0d ov=%b err=%b expected all 0",
               ro_enable, busy, done, count, overflow, err);
      errs++;
    end
  endtask
  task automatic test_basic();
    int lat;
    logic [CNT_W-1:0] c;
    logic ov, er;
    bit eb, bb;
    ro_half[1] = 15.0;
    run_meas(1, 240, 1'b0, lat, c, ov, er, eb, bb);
    check_valid("basic", 1, 240, lat, c, ov, er, eb, bb);
    @(posedge clk); #1;
    vecs++;
    if ({busy, done, ro_enable} !== '0) begin
      $display("FAIL basic_after: got busy=%b done=%b en=%b expected 0", busy, done, ro_enable);
      errs++;
    end
    vecs++;
    if (count !== c) begin
      $display("FAIL basic_hold: got %0d expected %0d", count, c);
      errs++;
    end
  endtask
  task automatic test_invalid();
    int sels[4] = '{5, 7, 2, 4};
    int gates[4] = '{100, 1, 0, 0};
    int lat;
    logic [CNT_W-1:0] c;
    logic ov, er;
    bit eb, bb;
    gates[3] = $urandom_range(1, 500);
    for (int i = 0; i < 4; i++) begin
      run_meas(sels[i], gates[i], 1'b0, lat, c, ov, er, eb, bb);
      vecs++;
      if (lat !== 1 || er !== 1'b1 || c !== '0 || ov !== 1'b0 || eb !== 1'b0) begin
        $display("FAIL invalid[%0d]: got lat=%0d err=%b count=%0d ov=%b en_bad=%b expected 1 1 0 0 0",
                 i, lat, er, c, ov, eb);
        errs++;
      end
    end
  endtask
  task automatic test_random();
    int lat, sel, g;
    logic [CNT_W-1:0] c;
    logic ov, er;
    bit eb, bb;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NUM_RO; k++) ro_half[k] = 3.0 + $urandom_range(0, 220) / 10.0;
      sel = $urandom_range(0, NUM_RO - 1);
      g = $urandom_range(20, 400);
      run_meas(sel, g, 1'b0, lat, c, ov, er, eb, bb);
      check_valid($sformatf("random[%0d]", i), sel, g, lat, c, ov, er, eb, bb);
    end
  endtask
  task automatic test_overflow();
    int lat;
    logic [CNT_W-1:0] c;
    logic ov, er;
    bit eb, bb;
    ro_half[2] = 2.0;
    run_meas(2, 800, 1'b0, lat, c, ov, er, eb, bb);
    check_valid("near_full", 2, 800, lat, c, ov, er, eb, bb);
    run_meas(2, 1000, 1'b0, lat, c, ov, er, eb, bb);
    vecs++;
    if (c !== CNT_W'(CMAX) || ov !== 1'b1 || er !== 1'b0) begin
      $display("FAIL overflow: got count=%0d ov=%b err=%b expected %0d 1 0", c, ov, er, CMAX);
      errs++;
    end
    vecs++;
    if (lat !== exp_lat(1000)) begin
      $display("FAIL overflow_latency: got %0d expected %0d", lat, exp_lat(1000));
      errs++;
    end
  endtask
  task automatic test_start_spam();
    int lat;
    logic [CNT_W-1:0] c;
    logic ov, er;
    bit eb, bb;
    ro_half[0] = 12.5;
    run_meas(0, 200, 1'b1, lat, c, ov, er, eb, bb);
    check_valid("spam", 0, 200, lat, c, ov, er, eb, bb);
    vecs++;
    if (busy !== 1'b0) begin
      $display("FAIL spam_done_ignored: got busy=%b expected 0", busy);
      errs++;
    end
    repeat (5) @(posedge clk);
    #1;
    vecs++;
    if (count !== c || done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL spam_hold: got count=%0d done=%b busy=%b expected %0d 0 0", count, done, busy, c);
      errs++;
    end
  endtask
  task automatic test_reset_mid();
    int lat;
    logic [CNT_W-1:0] c;
    logic ov, er;
    bit eb, bb;
    ro_half[3] = 10.0;
    @(posedge clk); #1;
    start = 1'b1;
    ro_sel = 3'd3;
    gate_cycles = 16'd500;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vecs++;
    if ({ro_enable, busy, done, count, overflow, err} !== '0) begin
      $display("FAIL reset_mid: got en=%b busy=%b done=%b count=%0d ov=%b err=%b expected all 0",
               ro_enable, busy, done, count, overflow, err);
      errs++;
    end
    @(negedge clk) rst_n = 1'b1;
    run_meas(3, 160, 1'b0, lat, c, ov, er, eb, bb);
    check_valid("after_reset", 3, 160, lat, c, ov, er, eb, bb);
  endtask
  task automatic test_back_to_back();
    int lat;
    logic [CNT_W-1:0] c0, c3;
    logic ov, er;
    bit eb, bb;
    ro_half[0] = 10.0;
    ro_half[3] = 20.0;
    run_meas(0, 320, 1'b0, lat, c0, ov, er, eb, bb);
    check_valid("b2b_sel0", 0, 320, lat, c0, ov, er, eb, bb);
    run_meas(3, 320, 1'b0, lat, c3, ov, er, eb, bb);
    check_valid("b2b_sel3", 3, 320, lat, c3, ov, er, eb, bb);
    vecs++;
    if (c0 <= c3) begin
      $display("FAIL b2b_ratio: got sel0=%0d sel3=%0d expected sel0 about twice sel3", c0, c3);
      errs++;
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_random();
    test_overflow();
    test_start_spam();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
